sass_t: RTL

Single-wire SASS transmitter: serialises a `data_l`-bit word onto the idle-high line `s` as start bit, data bits LSB first, then stop bit, each held for a fixed number of clock cycles. It is the transmit end of the SASS link: it drives the line sampled by the SASS receiver `sass_r` and uses the same parameter set. With identical parameters, it delivers words to the receiver without error.

---
 rtl/sass_t.sv | 114 +++++++++++
 1 files changed

// File: rtl/sass_t.sv
// sass_t: single-wire SASS transmitter.
// Sends a data_l-bit word on the idle-high line s. The frame is one start bit (low),
// then the data bits LSB first, then one stop bit (high). Each bit lasts BP = t_d+1 clocks,
// where t_d = clk_f*t/range.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   data - word to send, captured when send is accepted
//   send - request, accepted when send && !busy
//   s    - transmission line (registered, idle high)
//   busy - high from the cycle after accept until frame end
//   done - one-cycle pulse in the first idle cycle after the stop bit
module sass_t #(
  parameter int unsigned data_l = 14,
  parameter int unsigned clk_f  = 50_000_000,
  parameter int unsigned range  = 1_000_000,
  parameter int unsigned t      = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [data_l-1:0] data,
  input  logic              send,
  output logic              s,
  output logic              busy,
  output logic              done
);

  // 64-bit product: clk_f*t overflows 32 bits for the default parameter set
  localparam longint unsigned T_D_L = (64'(clk_f) * 64'(t)) / 64'(range);
  localparam int unsigned T_D = 32'(T_D_L);
  localparam int unsigned CW  = $clog2(T_D + 1);
  localparam int unsigned BW  = $clog2(data_l + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [BW-1:0]     bit_idx;
  logic [data_l-1:0] buffer;
  logic              bit_end;

  assign bit_end = (count == CW'(T_D));

  // Frame sequencer; s is always loaded one cycle ahead so it only toggles at bit boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      bit_idx <= '0;
      buffer  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          s    <= 1'b1;
          busy <= 1'b0;
          if (send) begin
            buffer  <= data;
            count   <= '0;
            bit_idx <= '0;
            s       <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            count   <= '0;
            bit_idx <= '0;
            s       <= buffer[0];
            state   <= DATA;
          end else begin
            count <= count + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            count <= '0;
            if (bit_idx == BW'(data_l - 1)) begin
              s     <= 1'b1;
              state <= STOP;
            end else begin
              // buffer[0] always holds the bit currently on the line
              bit_idx <= bit_idx + BW'(1);
              buffer  <= buffer >> 1;
              s       <= buffer[1];
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          s     <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
